// File: rtl/sprite_color_mapper_if.sv
// Sprite position load channel: valid/ready transfer of the requested sprite top-left corner.
interface sprite_color_mapper_if;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       pos_valid;
    logic       pos_ready;

    modport master (output pos_x, output pos_y, output pos_valid, input pos_ready);
    modport slave  (input pos_x, input pos_y, input pos_valid, output pos_ready);
endinterface

// File: rtl/sprite_color_mapper.sv
// VGA pixel stage: overlays one animated 32x32 palette sprite on a flat background,
// with sync/blank delayed 3 cycles and sprite position committed at vsync.
module sprite_color_mapper #(
    parameter int unsigned SPR_W      = 32,
    parameter int unsigned SPR_H      = 32,
    parameter int unsigned N_FRAMES   = 4,
    parameter int unsigned ANIM_DIV   = 6,
    parameter logic [23:0] BG_COLOR   = 24'h000040,
    parameter logic [3:0]  TRANSP_IDX = 4'd0
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic                   blank_in,
    input  logic                   hs_in,
    input  logic                   vs_in,
    sprite_color_mapper_if.slave   pos,
    output logic [11:0]            rom_addr,
    input  logic [3:0]             rom_data,
    output logic [7:0]             VGA_R,
    output logic [7:0]             VGA_G,
    output logic [7:0]             VGA_B,
    output logic                   hs_out,
    output logic                   vs_out,
    output logic                   blank_out,
    output logic                   frame_tick
);
    localparam int unsigned XW = $clog2(SPR_W);
    localparam int unsigned YW = $clog2(SPR_H);
    localparam int unsigned FW = $clog2(N_FRAMES);
    localparam int unsigned AW = FW + YW + XW;
    localparam int unsigned CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [9:0]    act_x, act_y, shadow_x, shadow_y;
    logic          shadow_full;
    logic [FW-1:0] anim_idx;
    logic [CW-1:0] frame_cnt;

    logic          hit1, blank1, hs1, vs1;
    logic          hit2, blank2, hs2, vs2;
    logic [23:0]   rgb;

    logic [10:0]   dx, dy;
    logic          hit_c;
    logic [AW-1:0] addr_c;
    logic          vs_fall;
    logic [23:0]   pal_c;

    // Offset into the sprite; 11-bit so coordinates left/above the sprite go negative instead of wrapping.
    always_comb begin
        dx     = {1'b0, DrawX} - {1'b0, act_x};
        dy     = {1'b0, DrawY} - {1'b0, act_y};
        hit_c  = !dx[10] && !dy[10] && (dx < 11'(SPR_W)) && (dy < 11'(SPR_H));
        addr_c = {anim_idx, dy[YW-1:0], dx[XW-1:0]};
    end

    assign vs_fall = vs1 && !vs_in;

    // Fixed 16-entry palette.
    always_comb begin
        pal_c = 24'h000000;
        case (rom_data)
            4'h0: pal_c = 24'h000000;
            4'h1: pal_c = 24'hFFFFFF;
            4'h2: pal_c = 24'hFF0000;
            4'h3: pal_c = 24'h00FF00;
            4'h4: pal_c = 24'h0000FF;
            4'h5: pal_c = 24'hFFFF00;
            4'h6: pal_c = 24'hFF00FF;
            4'h7: pal_c = 24'h00FFFF;
            4'h8: pal_c = 24'h808080;
            4'h9: pal_c = 24'hC0C0C0;
            4'hA: pal_c = 24'h800000;
            4'hB: pal_c = 24'h008000;
            4'hC: pal_c = 24'h000080;
            4'hD: pal_c = 24'hFF8000;
            4'hE: pal_c = 24'h8000FF;
            4'hF: pal_c = 24'h804000;
            default: pal_c = 24'h000000;
        endcase
    end

    // Pixel pipeline: the ROM address is formed from the live coordinates so the 1-cycle ROM read lands in S3.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr  <= 12'd0;
            hit1      <= 1'b0;
            blank1    <= 1'b0;
            hs1       <= 1'b1;
            vs1       <= 1'b1;
            hit2      <= 1'b0;
            blank2    <= 1'b0;
            hs2       <= 1'b1;
            vs2       <= 1'b1;
            rgb       <= 24'h000000;
            hs_out    <= 1'b1;
            vs_out    <= 1'b1;
            blank_out <= 1'b0;
        end else begin
            rom_addr  <= 12'(addr_c);
            hit1      <= hit_c;
            blank1    <= blank_in;
            hs1       <= hs_in;
            vs1       <= vs_in;
            hit2      <= hit1;
            blank2    <= blank1;
            hs2       <= hs1;
            vs2       <= vs1;
            hs_out    <= hs2;
            vs_out    <= vs2;
            blank_out <= blank2;
            if (!blank2)
                rgb <= 24'h000000;
            else if (!hit2 || rom_data == TRANSP_IDX)
                rgb <= BG_COLOR;
            else
                rgb <= pal_c;
        end
    end

    assign VGA_R = rgb[23:16];
    assign VGA_G = rgb[15:8];
    assign VGA_B = rgb[7:0];

    // Position shadow/commit; pos_ready low while full, so load and commit never coincide.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            act_x         <= 10'd0;
            act_y         <= 10'd0;
            shadow_x      <= 10'd0;
            shadow_y      <= 10'd0;
            shadow_full   <= 1'b0;
            pos.pos_ready <= 1'b1;
        end else if (pos.pos_valid && pos.pos_ready) begin
            shadow_x      <= pos.pos_x;
            shadow_y      <= pos.pos_y;
            shadow_full   <= 1'b1;
            pos.pos_ready <= 1'b0;
        end else if (vs_fall && shadow_full) begin
            act_x         <= shadow_x;
            act_y         <= shadow_y;
            shadow_full   <= 1'b0;
            pos.pos_ready <= 1'b1;
        end
    end

    // Frame tick and animation step.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
            anim_idx   <= '0;
        end else begin
            frame_tick <= vs_fall;
            if (frame_tick) begin
                if (frame_cnt == CW'(ANIM_DIV - 1)) begin
                    frame_cnt <= '0;
                    anim_idx  <= anim_idx + FW'(1);
                end else begin
                    frame_cnt <= frame_cnt + CW'(1);
                end
            end
        end
    end
endmodule
